// File: rtl/ack_queue_mc.sv
// ---------------------------------------------------------------------------
// ack_queue_mc
//
// Multi-channel acknowledgement queue. Each application channel reports the
// latest sequence number it wants acknowledged. The block remembers at most
// one pending value per channel. A newer value overwrites an older unsent one
// and is counted as coalesced. A value equal to the last one sent is dropped
// as a duplicate. Pending channels are served round-robin. Each ack goes out
// as a single-beat AXI-Stream frame.
//
// Parameters
//   NUM_CH      number of application channels (1..8)
//   SEQ_WIDTH   sequence-number width (8..32)
//   DATA_WIDTH  AXIS tdata width (64..512, multiple of 64)
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   seq_in          channel k sequence number at [k*SEQ_WIDTH +: SEQ_WIDTH]
//   seq_valid       bit k qualifies channel k of seq_in for one cycle
//   tx_tdata        ack payload: [31:0] sequence, [39:32] channel id
//   tx_tkeep        byte enables, low 8 bytes only
//   tx_tuser        sideband, [7:0] channel id
//   tx_tvalid       beat valid
//   tx_tlast        end of frame (always set with a beat)
//   tx_tready       downstream ready
//   stat_coalesced  saturating count of pending acks overwritten before send
// ---------------------------------------------------------------------------
module ack_queue_mc #(
    parameter int NUM_CH     = 2,
    parameter int SEQ_WIDTH  = 32,
    parameter int DATA_WIDTH = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*SEQ_WIDTH-1:0] seq_in,
    input  logic [NUM_CH-1:0]           seq_valid,
    output logic [DATA_WIDTH-1:0]       tx_tdata,
    output logic [DATA_WIDTH/8-1:0]     tx_tkeep,
    output logic [63:0]                 tx_tuser,
    output logic                        tx_tvalid,
    output logic                        tx_tlast,
    input  logic                        tx_tready,
    output logic [31:0]                 stat_coalesced
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;
    state_t next_state;

    // Registered copy of the inputs. This adds one cycle of input latency
    // and keeps seq_in and seq_valid off the grant and compare paths.
    logic [NUM_CH*SEQ_WIDTH-1:0] in_seq;
    logic [NUM_CH-1:0]           in_valid;

    // Per-channel bookkeeping
    logic [SEQ_WIDTH-1:0] pend_seq  [NUM_CH];
    logic [SEQ_WIDTH-1:0] last_sent [NUM_CH];
    logic [NUM_CH-1:0]    pend;
    logic [NUM_CH-1:0]    sent_valid;

    logic [CH_W-1:0]      last_grant;

    // Beat being presented while in SEND
    logic [SEQ_WIDTH-1:0] beat_seq;
    logic [CH_W-1:0]      beat_ch;

    // Arbitration results
    logic                 grant_found;
    logic [CH_W-1:0]      grant_idx;
    logic                 do_grant;
    logic [NUM_CH-1:0]    granted;

    // Per-channel capture decisions for this cycle
    logic [NUM_CH-1:0]    load_vec;
    logic [NUM_CH-1:0]    coal_vec;
    logic [3:0]           coal_cnt;
    logic [32:0]          stat_sum;
    logic [31:0]          stat_next;

    // -----------------------------------------------------------------------
    // Round-robin search. It starts at the channel after the last one granted,
    // so a busy low-numbered channel cannot starve the others.
    // -----------------------------------------------------------------------
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(last_grant) + i) % NUM_CH;
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

    assign do_grant = (state == IDLE) && grant_found;

    // -----------------------------------------------------------------------
    // Capture decisions. A channel granted on this edge is judged against its
    // post-grant view. Its pending flag is already clear, and the value being
    // granted now counts as the last one sent. A new value arriving on the
    // grant edge therefore opens a fresh pending entry rather than coalescing.
    // It is dropped if it repeats the granted value.
    // -----------------------------------------------------------------------
    always_comb begin
        logic                 eff_pend;
        logic                 eff_sent;
        logic [SEQ_WIDTH-1:0] eff_last;
        logic [SEQ_WIDTH-1:0] new_seq;
        logic                 dup;
        eff_pend = 1'b0;
        eff_sent = 1'b0;
        eff_last = '0;
        new_seq  = '0;
        dup      = 1'b0;
        granted  = '0;
        load_vec = '0;
        coal_vec = '0;
        coal_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            granted[k]  = do_grant && (grant_idx == CH_W'(k));
            eff_pend    = pend[k] && !granted[k];
            eff_sent    = sent_valid[k] || granted[k];
            eff_last    = granted[k] ? pend_seq[k] : last_sent[k];
            new_seq     = in_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
            dup         = eff_sent && (new_seq == eff_last) && !eff_pend;
            load_vec[k] = in_valid[k] && !dup;
            coal_vec[k] = in_valid[k] && !dup && eff_pend;
            coal_cnt    = coal_cnt + 4'(coal_vec[k]);
        end
    end

    // Several channels can coalesce in one cycle, so the counter adds the
    // whole count and clamps at all-ones instead of wrapping.
    always_comb begin
        stat_sum  = {1'b0, stat_coalesced} + 33'(coal_cnt);
        stat_next = stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
    end

    // -----------------------------------------------------------------------
    // FSM state register. Reset in SEND drops the beat without a handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state. Leaving SEND always passes through IDLE, which puts
    // one idle cycle between back-to-back beats.
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (tx_tready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs. Every field is forced to zero outside SEND, so nothing
    // stale is shown after reset or after a handshake.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [31:0] seq32;
        logic [7:0]  ch8;
        seq32                    = '0;
        ch8                      = '0;
        seq32[SEQ_WIDTH-1:0]     = beat_seq;
        ch8[CH_W-1:0]            = beat_ch;
        tx_tvalid                = 1'b0;
        tx_tlast                 = 1'b0;
        tx_tdata                 = '0;
        tx_tkeep                 = '0;
        tx_tuser                 = '0;
        if (state == SEND) begin
            tx_tvalid       = 1'b1;
            tx_tlast        = 1'b1;
            tx_tdata[31:0]  = seq32;
            tx_tdata[39:32] = ch8;
            tx_tkeep[7:0]   = 8'hFF;
            tx_tuser[7:0]   = ch8;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers: input stage, per-channel state, grant pointer,
    // beat contents and the coalesce statistic.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            in_seq         <= '0;
            in_valid       <= '0;
            pend           <= '0;
            sent_valid     <= '0;
            last_grant     <= CH_W'(NUM_CH - 1);
            beat_seq       <= '0;
            beat_ch        <= '0;
            stat_coalesced <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                pend_seq[k]  <= '0;
                last_sent[k] <= '0;
            end
        end else begin
            in_seq         <= seq_in;
            in_valid       <= seq_valid;
            stat_coalesced <= stat_next;
            for (int k = 0; k < NUM_CH; k++) begin
                if (load_vec[k]) begin
                    pend[k]     <= 1'b1;
                    pend_seq[k] <= in_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
                end else if (granted[k]) begin
                    pend[k] <= 1'b0;
                end
                if (granted[k]) begin
                    last_sent[k]  <= pend_seq[k];
                    sent_valid[k] <= 1'b1;
                end
            end
            if (do_grant) begin
                last_grant <= grant_idx;
                beat_ch    <= grant_idx;
                beat_seq   <= pend_seq[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_ack_queue_mc.sv
// ---------------------------------------------------------------------------
// tb_ack_queue_mc
//
// Self-checking bench for ack_queue_mc with four channels, 8-bit sequence
// numbers and a 128-bit stream. The reference model works at the level of
// the behaviour rules. Arrivals take one cycle to reach the pending store.
// An idle queue grants the next pending channel round-robin. The grant
// happens before that cycle's arrivals are judged. A beat stays in flight
// until it is accepted.
// ---------------------------------------------------------------------------
module tb_ack_queue_mc;

    localparam int NCH = 4;
    localparam int SW  = 8;
    localparam int DW  = 128;

    logic              clk;
    logic              reset;
    logic [NCH*SW-1:0] seq_in;
    logic [NCH-1:0]    seq_valid;
    logic [DW-1:0]     tx_tdata;
    logic [DW/8-1:0]   tx_tkeep;
    logic [63:0]       tx_tuser;
    logic              tx_tvalid;
    logic              tx_tlast;
    logic              tx_tready;
    logic [31:0]       stat_coalesced;

    ack_queue_mc #(
        .NUM_CH    (NCH),
        .SEQ_WIDTH (SW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seq_in        (seq_in),
        .seq_valid     (seq_valid),
        .tx_tdata      (tx_tdata),
        .tx_tkeep      (tx_tkeep),
        .tx_tuser      (tx_tuser),
        .tx_tvalid     (tx_tvalid),
        .tx_tlast      (tx_tlast),
        .tx_tready     (tx_tready),
        .stat_coalesced(stat_coalesced)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    logic [SW-1:0] m_pend_seq [NCH];
    bit            m_pend     [NCH];
    logic [SW-1:0] m_last     [NCH];
    bit            m_sent     [NCH];
    int            m_last_grant;
    logic [31:0]   m_stat;
    bit            m_busy;
    logic [7:0]    m_beat_ch;
    logic [SW-1:0] m_beat_seq;
    bit            st_valid   [NCH];
    logic [SW-1:0] st_seq     [NCH];
    int            rst_age = 99;

    // Channel ids of beats the DUT actually handed over
    logic [7:0]    dut_beats[$];

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs the bench drives.
    task automatic modelStep();
        bit was_idle;
        bit found;
        int cand;
        if (reset) begin
            rst_age      = 0;
            m_busy       = 0;
            m_stat       = '0;
            m_last_grant = NCH - 1;
            for (int k = 0; k < NCH; k++) begin
                m_pend[k] = 0; m_sent[k] = 0; m_pend_seq[k] = '0; m_last[k] = '0;
            end
        end else begin
            if (rst_age < 99) rst_age++;
            was_idle = !m_busy;
            if (m_busy && tx_tready) m_busy = 0;
            if (was_idle) begin
                found = 0;
                for (int i = 1; i <= NCH; i++) begin
                    cand = (m_last_grant + i) % NCH;
                    if (!found && m_pend[cand]) begin
                        found        = 1;
                        m_busy       = 1;
                        m_beat_ch    = 8'(cand);
                        m_beat_seq   = m_pend_seq[cand];
                        m_last[cand] = m_pend_seq[cand];
                        m_sent[cand] = 1;
                        m_pend[cand] = 0;
                        m_last_grant = cand;
                    end
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (st_valid[k] && !(m_sent[k] && st_seq[k] == m_last[k] && !m_pend[k])) begin
                    if (m_pend[k] && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
                    m_pend_seq[k] = st_seq[k];
                    m_pend[k]     = 1;
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            st_valid[k] = reset ? 1'b0 : seq_valid[k];
            st_seq[k]   = seq_in[k*SW +: SW];
        end
    endtask

    task automatic compareAll();
        logic [127:0] exp_data;
        logic [63:0]  exp_user;
        checkOutput("tvalid", tx_tvalid, m_busy);
        checkOutput("stat_coalesced", stat_coalesced, m_stat);
        if (m_busy) begin
            exp_data        = '0;
            exp_data[31:0]  = {24'h0, m_beat_seq};
            exp_data[39:32] = m_beat_ch;
            exp_user        = {56'h0, m_beat_ch};
            checkOutput("tdata", tx_tdata, exp_data);
            checkOutput("tkeep", tx_tkeep, 16'h00FF);
            checkOutput("tuser", tx_tuser, exp_user);
            checkOutput("tlast", tx_tlast, 1'b1);
        end
        if (rst_age <= 1) begin
            checkOutput("reset_tdata", tx_tdata, 128'h0);
            checkOutput("reset_tkeep", tx_tkeep, 16'h0);
            checkOutput("reset_tuser", tx_tuser, 64'h0);
            checkOutput("reset_tlast", tx_tlast, 1'b0);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge and compare
    // away from the edge.
    task automatic applyStimulus(input bit rst, input logic [NCH-1:0] v,
                                 input logic [NCH*SW-1:0] s, input bit rdy);
        reset     = rst;
        seq_valid = v;
        seq_in    = s;
        tx_tready = rdy;
        if (tx_tvalid && rdy && !rst) dut_beats.push_back(tx_tuser[7:0]);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, rdy);
    endtask

    function automatic logic [SW-1:0] pickSeq();
        int pick;
        pick = int'($urandom_range(0, 7));
        if (pick < 4) return SW'(pick);
        if (pick == 4) return 8'hFF;
        return SW'($urandom);
    endfunction

    initial begin
        int low_burst;
        bit rdy;
        logic [NCH-1:0]    v;
        logic [NCH*SW-1:0] s;
        reset     = 1'b1;
        seq_valid = '0;
        seq_in    = '0;
        tx_tready = 1'b1;

        // Reset, with arrivals that must be ignored
        applyStimulus(1, '0, '0, 1);
        applyStimulus(1, 4'hF, 32'h0403_0201, 1);
        applyStimulus(1, '0, '0, 1);
        idleCycles(2, 1);

        // Single ack on channel 0, then a duplicate of it
        applyStimulus(0, 4'b0001, 32'h0000_0001, 1);
        idleCycles(5, 1);
        applyStimulus(0, 4'b0001, 32'h0000_0001, 1);
        idleCycles(5, 1);
        checkOutput("dup_stat_zero", stat_coalesced, 32'h0);

        // Stalled downstream with newer values coalescing
        applyStimulus(0, 4'b0001, 32'h0000_0001, 0);
        applyStimulus(0, 4'b0001, 32'h0000_0003, 0);
        applyStimulus(0, 4'b0001, 32'h0000_0005, 0);
        idleCycles(4, 0);
        idleCycles(8, 1);

        // Two channels at once, twice
        applyStimulus(0, 4'b0011, 32'h0000_0F03, 1);
        idleCycles(6, 1);
        applyStimulus(0, 4'b0011, 32'h0000_0907, 1);
        idleCycles(6, 1);

        // Wrap from max to zero is a new value
        applyStimulus(0, 4'b0100, 32'h00FF_0000, 1);
        idleCycles(4, 1);
        applyStimulus(0, 4'b0100, 32'h0000_0000, 1);
        idleCycles(5, 1);

        // Reset while a beat is stalled
        applyStimulus(1, '0, '0, 1);
        idleCycles(1, 1);
        applyStimulus(0, 4'b0001, 32'h0000_0020, 0);
        idleCycles(3, 0);
        checkOutput("stalled_tvalid", tx_tvalid, 1'b1);
        applyStimulus(1, '0, '0, 0);
        checkOutput("dropped_tvalid", tx_tvalid, 1'b0);
        idleCycles(6, 1);
        checkOutput("dropped_stat", stat_coalesced, 32'h0);

        // All channels pending continuously: strict rotation from channel 0
        applyStimulus(1, '0, '0, 1);
        dut_beats.delete();
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < NCH; k++) s[k*SW +: SW] = SW'(c * NCH + k);
            applyStimulus(0, 4'hF, s, 1);
        end
        checkOutput("rr_beats_seen", dut_beats.size() >= 5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_beats.size()) checkOutput($sformatf("rr_grant%0d", i), dut_beats[i], 8'(i % NCH));
        end
        idleCycles(12, 1);

        // Randomized traffic, backpressure and occasional reset
        low_burst = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NCH; k++) begin
                v[k]          = ($urandom_range(0, 2) == 0);
                s[k*SW +: SW] = pickSeq();
            end
            if (low_burst > 0) begin
                rdy = 0;
                low_burst--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) low_burst = int'($urandom_range(5, 20));
            end
            applyStimulus($urandom_range(0, 299) == 0, v, s, rdy);
        end
        idleCycles(12, 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
